// File: rtl/mem_port_arbiter.sv
// Shares the single memory bus between instruction fetch and load/store.
// One transaction at a time, with flush drain and bus-timeout abort.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_kill,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    output logic            if_err,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            d_err,
    output logic            d_stall,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    input  logic            bus_rvalid,
    input  logic [DW-1:0]   bus_rdata
);

    localparam int TW = 10;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          last_d;
    logic [TW-1:0] timer;
    logic          expired;
    logic          i_ok;
    logic          grant_d;
    logic          grant_i;

    assign expired = (timer == TLAST) & ~bus_rvalid;
    assign i_ok    = if_req & ~if_kill;
    // data wins unless the previous winner was data and a fetch is waiting
    assign grant_d = d_req & ~(i_ok & last_d);
    assign grant_i = i_ok & ~grant_d;

    assign bus_req  = (state != IDLE);
    assign if_rdata = if_done ? bus_rdata : '0;
    assign d_rdata  = d_done ? bus_rdata : '0;
    assign if_stall = if_req & ~if_done & ~if_err;
    assign d_stall  = d_req & ~d_done & ~d_err;

    always_comb begin
        state_nx = state;
        if_done  = 1'b0;
        if_err   = 1'b0;
        d_done   = 1'b0;
        d_err    = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nx = BUSY_D;
                end else if (grant_i) begin
                    state_nx = BUSY_I;
                end
            end
            BUSY_I: begin
                if (bus_rvalid) begin
                    state_nx = IDLE;
                    if_done  = ~if_kill;
                end else if (if_kill) begin
                    state_nx = expired ? IDLE : DRAIN;
                end else if (expired) begin
                    state_nx = IDLE;
                    if_err   = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus_rvalid) begin
                    state_nx = IDLE;
                    d_done   = 1'b1;
                end else if (expired) begin
                    state_nx = IDLE;
                    d_err    = 1'b1;
                end
            end
            DRAIN: begin
                if (bus_rvalid | expired) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            timer     <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
        end else begin
            state <= state_nx;
            if (d_done) begin
                last_d <= 1'b1;
            end else if (if_done) begin
                last_d <= 1'b0;
            end
            // a drained fetch keeps its original deadline
            if (state == IDLE) begin
                timer <= '0;
            end else if (!bus_rvalid) begin
                timer <= timer + TW'(1);
            end
            if (state == IDLE && grant_d) begin
                bus_we    <= d_we;
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
                bus_wstrb <= d_we ? d_wstrb : '0;
            end else if (state == IDLE && grant_i) begin
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                bus_wstrb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, bus command
// scoreboard and hand-written flush / timeout / reset sequences.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_err;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_err;
    logic          d_stall;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [3:0]    bus_wstrb;
    logic          bus_rvalid;
    logic [DW-1:0] bus_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .d_stall(d_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] rdata;
        int          stall;
    } vec_t;

    cmd_t        exp_q[$];
    cmd_t        cur;
    vec_t        tv[5];
    int          n_checks = 0;
    int          n_fail = 0;
    int          rsp_lat = -1;
    int          rsp_cnt = 0;
    logic [31:0] rsp_data = '0;
    logic        prev_req;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
        cmd_t c;
        c.we = we;
        c.addr = a;
        c.wdata = wd;
        c.wstrb = ws;
        exp_q.push_back(c);
    endtask

    task automatic wait_evt(input bit is_d, input int max_cyc,
                            output bit done, output bit err,
                            output logic [31:0] rd, output int stall_n,
                            output int busy_n, output int other_n);
        done = 0;
        err = 0;
        rd = '0;
        stall_n = 0;
        busy_n = 0;
        other_n = 0;
        for (int c = 0; c < max_cyc && !done && !err; c++) begin
            @(negedge clk);
            if (bus_req) busy_n++;
            if (is_d) begin
                if (d_stall) stall_n++;
                if (d_done) begin
                    done = 1;
                    rd = d_rdata;
                end
                if (d_err) err = 1;
                if (if_done | if_err) other_n++;
            end else begin
                if (if_stall) stall_n++;
                if (if_done) begin
                    done = 1;
                    rd = if_rdata;
                end
                if (if_err) err = 1;
                if (d_done | d_err) other_n++;
            end
        end
    endtask

    // bus slave: answers rsp_lat cycles after bus_req rises (-1 = never)
    initial begin
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                bus_rvalid = (rsp_cnt == rsp_lat);
                bus_rdata = (rsp_cnt == rsp_lat) ? rsp_data : '0;
                rsp_cnt++;
            end else begin
                bus_rvalid = 1'b0;
                bus_rdata = '0;
                rsp_cnt = 0;
            end
        end
    end

    // scoreboard: each new bus transaction must match the next expected one
    initial begin
        prev_req = 1'b0;
        cur = '{1'b0, 32'h0, 32'h0, 4'h0};
        forever begin
            @(negedge clk);
            if (bus_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_cmd: unexpected issue addr %h", bus_addr);
                end else begin
                    cur = exp_q.pop_front();
                    chk("bus_we", bus_we, cur.we);
                    chk("bus_addr", bus_addr, cur.addr);
                    chk("bus_wstrb", bus_wstrb, cur.wstrb);
                    if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
                end
            end
            if (bus_req && bus_rvalid) chk("bus_addr_hold", bus_addr, cur.addr);
            prev_req = bus_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          done;
        bit          err;
        logic [31:0] rd;
        int          stall_n;
        int          busy_n;
        int          other_n;

        tv[0] = '{1, 0, 32'h2000, 32'h0, 4'hF, 0, 32'hCAFEF00D, 1};
        tv[1] = '{1, 1, 32'h2004, 32'h12345678, 4'h3, 2, 32'h0, 3};
        tv[2] = '{1, 0, 32'h1FFC, 32'h0, 4'hF, 3, 32'hA5A5A5A5, 4};
        tv[3] = '{0, 0, 32'h104, 32'h0, 4'h0, 1, 32'h00500093, 2};
        tv[4] = '{0, 0, 32'h100, 32'h0, 4'h0, 3, 32'h00000013, 4};

        if_req = 0;
        if_addr = '0;
        if_kill = 0;
        d_req = 0;
        d_we = 0;
        d_addr = '0;
        d_wdata = '0;
        d_wstrb = '0;
        rst_n = 1;
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            rsp_lat = tv[i].lat;
            rsp_data = tv[i].rdata;
            push_cmd(tv[i].is_d & tv[i].we, tv[i].addr, tv[i].wdata,
                     (tv[i].is_d & tv[i].we) ? tv[i].wstrb : 4'h0);
            if (tv[i].is_d) begin
                d_req = 1;
                d_we = tv[i].we;
                d_addr = tv[i].addr;
                d_wdata = tv[i].wdata;
                d_wstrb = tv[i].wstrb;
            end else begin
                if_req = 1;
                if_addr = tv[i].addr;
            end
            wait_evt(tv[i].is_d, 20, done, err, rd, stall_n, busy_n, other_n);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_err", i), err, 0);
            if (!tv[i].we) chk($sformatf("v%0d_rdata", i), rd, tv[i].rdata);
            chk($sformatf("v%0d_stall", i), stall_n, tv[i].stall);
            chk($sformatf("v%0d_other", i), other_n, 0);
            @(posedge clk);
            #1;
            if_req = 0;
            d_req = 0;
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), tv[i].is_d ? d_done : if_done, 0);
        end

        // contention: store first, then a pending fetch beats a new load
        @(posedge clk);
        #1;
        rsp_lat = 1;
        rsp_data = 32'h00000297;
        if_req = 1;
        if_addr = 32'h300;
        d_req = 1;
        d_we = 1;
        d_addr = 32'h2000;
        d_wdata = 32'hDEADBEEF;
        d_wstrb = 4'hF;
        push_cmd(1, 32'h2000, 32'hDEADBEEF, 4'hF);
        push_cmd(0, 32'h300, 32'h0, 4'h0);
        wait_evt(1, 20, done, err, rd, stall_n, busy_n, other_n);
        chk("arb_store_done", done, 1);
        chk("arb_store_other", other_n, 0);
        @(posedge clk);
        #1;
        d_we = 0;
        d_addr = 32'h2004;
        push_cmd(0, 32'h2004, 32'h0, 4'h0);
        wait_evt(0, 20, done, err, rd, stall_n, busy_n, other_n);
        chk("arb_fetch_done", done, 1);
        chk("arb_fetch_rdata", rd, 32'h00000297);
        chk("arb_fetch_other", other_n, 0);
        @(posedge clk);
        #1;
        if_req = 0;
        wait_evt(1, 20, done, err, rd, stall_n, busy_n, other_n);
        chk("arb_load_done", done, 1);
        chk("arb_load_rdata", rd, 32'h00000297);
        @(posedge clk);
        #1;
        d_req = 0;

        // flush while fetch in flight: drain until the bus answers
        @(posedge clk);
        #1;
        rsp_lat = 2;
        rsp_data = 32'h11111111;
        if_req = 1;
        if_addr = 32'h400;
        push_cmd(0, 32'h400, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        if_kill = 1;
        @(negedge clk);
        chk("kill_busy_req", bus_req, 1);
        chk("kill_busy_done", if_done, 0);
        @(posedge clk);
        #1;
        if_kill = 0;
        if_req = 0;
        @(negedge clk);
        chk("drain_req", bus_req, 1);
        @(negedge clk);
        chk("drain_rvalid", bus_rvalid, 1);
        chk("drain_req_end", bus_req, 1);
        chk("drain_done", if_done, 0);
        chk("drain_err", if_err, 0);
        @(negedge clk);
        chk("drain_idle", bus_req, 0);

        // load the bus never answers
        @(posedge clk);
        #1;
        rsp_lat = -1;
        d_req = 1;
        d_we = 0;
        d_addr = 32'h3000;
        push_cmd(0, 32'h3000, 32'h0, 4'h0);
        wait_evt(1, 20, done, err, rd, stall_n, busy_n, other_n);
        chk("to_err", err, 1);
        chk("to_done", done, 0);
        chk("to_busy", busy_n, 4);
        chk("to_stall", stall_n, 4);
        chk("to_stall_at_err", d_stall, 0);
        @(posedge clk);
        #1;
        d_req = 0;
        @(negedge clk);
        chk("to_req_drop", bus_req, 0);
        chk("to_err_pulse", d_err, 0);

        // reset in the middle of a data transaction
        @(posedge clk);
        #1;
        d_req = 1;
        d_addr = 32'h5000;
        push_cmd(0, 32'h5000, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rstm_busy", bus_req, 1);
        #2 rst_n = 0;
        #1;
        chk("rstm_req", bus_req, 0);
        chk("rstm_done", d_done, 0);
        push_cmd(0, 32'h5000, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rsp_lat = 1;
        rsp_data = 32'h0BADF00D;
        rst_n = 1;
        wait_evt(1, 20, done, err, rd, stall_n, busy_n, other_n);
        chk("rstm_reissue_done", done, 1);
        chk("rstm_reissue_rdata", rd, 32'h0BADF00D);
        @(posedge clk);
        #1;
        d_req = 0;

        // kill and rvalid together, load waiting behind
        @(posedge clk);
        #1;
        rsp_lat = 0;
        rsp_data = 32'h22222222;
        if_req = 1;
        if_addr = 32'h600;
        push_cmd(0, 32'h600, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        if_kill = 1;
        d_req = 1;
        d_we = 0;
        d_addr = 32'h700;
        push_cmd(0, 32'h700, 32'h0, 4'h0);
        @(negedge clk);
        chk("kr_rvalid", bus_rvalid, 1);
        chk("kr_done", if_done, 0);
        @(posedge clk);
        #1;
        if_kill = 0;
        if_req = 0;
        rsp_lat = 1;
        rsp_data = 32'h33333333;
        @(negedge clk);
        chk("kr_idle", bus_req, 0);
        @(negedge clk);
        chk("kr_d_grant", bus_req, 1);
        wait_evt(1, 20, done, err, rd, stall_n, busy_n, other_n);
        chk("kr_d_done", done, 1);
        chk("kr_d_rdata", rd, 32'h33333333);
        @(posedge clk);
        #1;
        d_req = 0;

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory bus between the instruction-fetch requester (IF) and the load/store requester (MEM). It serialises one transaction at a time. It returns read data and a one-cycle completion pulse to the winning requester, and drives the per-requester stall lines consumed by the hazard/pipeline-control logic. It also discards fetches killed by a pipeline flush and aborts transactions the bus never answers.

Parameters:
AW, 32, address width
DW, 32, data width (byte strobes = DW/8)
TIMEOUT, 255, max cycles a bus transaction may wait for bus_rvalid before abort (1..1023)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request, held until if_done or if_kill
if_addr  input  AW  fetch address
if_kill  input  1  pipeline flush: abandon current/pending fetch
if_rdata  output  DW  fetched word, valid when if_done
if_done  output  1  one-cycle fetch completion pulse
if_err  output  1  one-cycle fetch timeout pulse
if_stall  output  1  if_req & ~if_done & ~if_err
d_req  input  1  load/store request, held until d_done or d_err
d_we  input  1  1 = store
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_wstrb  input  DW/8  byte enables (stores)
d_rdata  output  DW  load data, valid when d_done
d_done  output  1  one-cycle data completion pulse
d_err  output  1  one-cycle data timeout pulse
d_stall  output  1  d_req & ~d_done & ~d_err
bus_req  output  1  transaction active
bus_we  output  1  write
bus_addr  output  AW  address
bus_wdata  output  DW  write data
bus_wstrb  output  DW/8  strobes (0 on reads)
bus_rvalid  input  1  transaction complete; bus_rdata valid for reads
bus_rdata  input  DW  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE, last_d=0, timer=0, all outputs 0. Reset mid-transaction drops bus_req at once; no done/err pulse.
- States:
  - IDLE
  - BUSY_I: fetch in flight
  - BUSY_D: load/store in flight
  - DRAIN: killed fetch still owns the bus
- Bus command registers (bus_we/addr/wdata/wstrb) are loaded on entry to BUSY_I or BUSY_D and held stable while bus_req=1.
- bus_req=1 in BUSY_I, BUSY_D and DRAIN.
- A transaction ends in the cycle bus_rvalid=1 while bus_req=1. bus_rvalid is ignored when bus_req=0.
- IDLE arbitration, evaluated each cycle:
  - only d_req -> BUSY_D
  - only (if_req & ~if_kill) -> BUSY_I
  - both -> BUSY_D, unless last_d=1, then BUSY_I
  - neither -> stay in IDLE
- last_d is set when a D transaction completes and cleared when an I transaction completes. Data has priority, but a pending fetch is never starved by back-to-back loads/stores.
- BUSY_I + bus_rvalid: if_rdata<=bus_rdata, if_done=1 for that cycle (combinational from bus_rvalid, registered rdata not required), -> IDLE.
- BUSY_I + if_kill (without bus_rvalid) -> DRAIN. BUSY_I + if_kill + bus_rvalid same cycle -> IDLE, no if_done.
- DRAIN + bus_rvalid -> IDLE; data discarded, no pulses. if_kill in DRAIN has no further effect.
- BUSY_D + bus_rvalid: d_rdata=bus_rdata (loads), d_done=1, -> IDLE. if_kill does not affect data transactions.
- Minimum latency: request seen in IDLE at cycle N, bus_req at N+1, done at N+1 if bus_rvalid is already high. A new arbitration happens in IDLE at N+2 at the earliest (one idle turnaround cycle).
- Timeout:
  - timer clears on entry to any busy state and increments each busy cycle without bus_rvalid.
  - When timer==TIMEOUT-1 and no bus_rvalid: drop bus_req, pulse if_err (BUSY_I), d_err (BUSY_D) or nothing (DRAIN), -> IDLE.
  - Simultaneous bus_rvalid wins over timeout.
- Exactly one of done/err pulses per accepted, non-killed transaction; never both requesters in the same cycle.

Test Plan:
- if_req=1 addr 0x100 alone, bus_rvalid 3 cycles after bus_req with rdata 0x00000013 -> bus_addr=0x100, if_stall high 4 cycles, if_done one pulse with if_rdata=0x13, d_done stays 0.
- if_req and d_req (store, addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF) both high in IDLE, last_d=0 -> store issued first with bus_we=1 and correct strobes; the fetch is issued after completion. With d_req re-asserted at the same time the fetch is pending (last_d=1), the fetch wins the next arbitration.
- Fetch in BUSY_I, if_kill pulsed before bus_rvalid, bus_rvalid two cycles later -> DRAIN, bus_req held until rvalid, no if_done/if_err, IDLE afterwards.
- TIMEOUT=4, load issued, bus_rvalid never asserted -> bus_req drops after 4 busy cycles, d_err single pulse, d_stall falls the same cycle.
- rst_n pulled low while in BUSY_D -> bus_req=0 immediately (asynchronous), no d_done. After release with d_req still high -> the transaction is re-issued from IDLE.
- bus_rvalid and if_kill in the same BUSY_I cycle -> return to IDLE, no if_done; a following d_req is granted in the next cycle.
